// File: rtl/move_sequencer_if.sv
// Move/engine handshake bundle for the match-3 move sequencer.
// master: the sequencer. slave: the UI and board engines around it.
interface move_sequencer_if #(
  parameter int SCORE_W = 16
);
  // Move request
  logic               move_valid;
  logic               move_ready;
  logic [2:0]         move_r0;
  logic [2:0]         move_c0;
  logic [2:0]         move_r1;
  logic [2:0]         move_c1;
  // Board swap command
  logic               swap_en;
  logic [2:0]         swap_r0;
  logic [2:0]         swap_c0;
  logic [2:0]         swap_r1;
  logic [2:0]         swap_c1;
  // Engine start/done pairs
  logic               match_start;
  logic               match_done;
  logic               match_found;
  logic [6:0]         match_count;
  logic               clear_start;
  logic               clear_done;
  logic               refresh_start;
  logic               refresh_done;
  // Status
  logic               busy;
  logic               move_done;
  logic               move_rejected;
  logic               seq_error;
  logic [SCORE_W-1:0] score;
  logic [2:0]         combo;

  modport master (
    input  move_valid, move_r0, move_c0, move_r1, move_c1,
    input  match_done, match_found, match_count, clear_done, refresh_done,
    output move_ready, swap_en, swap_r0, swap_c0, swap_r1, swap_c1,
    output match_start, clear_start, refresh_start,
    output busy, move_done, move_rejected, seq_error, score, combo
  );

  modport slave (
    output move_valid, move_r0, move_c0, move_r1, move_c1,
    output match_done, match_found, match_count, clear_done, refresh_done,
    input  move_ready, swap_en, swap_r0, swap_c0, swap_r1, swap_c1,
    input  match_start, clear_start, refresh_start,
    input  busy, move_done, move_rejected, seq_error, score, combo
  );
endinterface

// File: rtl/move_sequencer.sv
// Step controller for the 8x8 match-3 board: takes one swap move, runs
// swap -> match -> clear -> refresh until the board settles, reverts
// illegal moves, and keeps a saturating score plus cascade counter.
//
// Handshake: a move is accepted on a rising edge where move_valid and
// move_ready are both high; move_ready is high only while idle, and a
// request seen while busy is dropped, not queued. Every *_start is a
// one-cycle pulse, only one is outstanding at a time, and a *_done is
// honoured only in the state waiting for it.
module move_sequencer #(
  parameter int SCORE_W   = 16,
  parameter int COMBO_MAX = 7,
  parameter int TIMEOUT   = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  move_sequencer_if.master bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE, CHECK, SWAP, MATCH_W, CLEAR_W, REFR_W, UNSWAP, FINISH
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int PW   = SCORE_W + 3;

  state_t             state;
  logic [WD_W-1:0]    wdog;
  logic [2:0]         r0, c0, r1, c1;
  logic               adj_q;
  logic [SCORE_W-1:0] score;
  logic [2:0]         combo;
  logic               ready, busy, seq_error;
  logic               swap_en, match_start, clear_start, refresh_start;
  logic               move_done, move_rejected;

  logic [2:0]         dr, dc;
  logic               adjacent;
  logic [PW-1:0]      product, sum;
  logic [SCORE_W-1:0] score_next;
  logic [2:0]         combo_next;
  logic               wd_expired;

  // Adjacency of the requested cells: Manhattan distance of exactly one.
  always_comb begin
    dr       = (bus.move_r0 >= bus.move_r1) ? bus.move_r0 - bus.move_r1 : bus.move_r1 - bus.move_r0;
    dc       = (bus.move_c0 >= bus.move_c1) ? bus.move_c0 - bus.move_c1 : bus.move_c1 - bus.move_c0;
    adjacent = (({1'b0, dr} + {1'b0, dc}) == 4'd1);
  end

  // Score uses the pre-increment combo; widened product saturates into SCORE_W.
  always_comb begin
    product    = PW'(bus.match_count) * PW'({1'b0, combo} + 4'd1);
    sum        = PW'(score) + product;
    score_next = (sum > PW'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    combo_next = (combo >= 3'(COMBO_MAX)) ? 3'(COMBO_MAX) : combo + 3'd1;
    wd_expired = (wdog == WD_W'(TIMEOUT - 1));
  end

  // Sequencer FSM with registered pulses, status, score and watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wdog          <= '0;
      {r0, c0, r1, c1} <= '0;
      adj_q         <= 1'b0;
      score         <= '0;
      combo         <= '0;
      ready         <= 1'b1;
      busy          <= 1'b0;
      seq_error     <= 1'b0;
      swap_en       <= 1'b0;
      match_start   <= 1'b0;
      clear_start   <= 1'b0;
      refresh_start <= 1'b0;
      move_done     <= 1'b0;
      move_rejected <= 1'b0;
    end else begin
      swap_en       <= 1'b0;
      match_start   <= 1'b0;
      clear_start   <= 1'b0;
      refresh_start <= 1'b0;
      move_done     <= 1'b0;
      move_rejected <= 1'b0;
      case (state)
        IDLE: if (bus.move_valid) begin
          r0    <= bus.move_r0;
          c0    <= bus.move_c0;
          r1    <= bus.move_r1;
          c1    <= bus.move_c1;
          adj_q <= adjacent;
          combo <= '0;
          // A non-adjacent move is flagged during the CHECK cycle itself.
          move_rejected <= ~adjacent;
          ready <= 1'b0;
          busy  <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (adj_q) begin
          swap_en <= 1'b1;
          state   <= SWAP;
        end else begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        SWAP: begin
          match_start <= 1'b1;
          wdog        <= '0;
          state       <= MATCH_W;
        end
        MATCH_W: if (bus.match_done) begin
          if (bus.match_found) begin
            score       <= score_next;
            combo       <= combo_next;
            clear_start <= 1'b1;
            wdog        <= '0;
            state       <= CLEAR_W;
          end else if (combo == 3'd0) begin
            swap_en       <= 1'b1;
            move_rejected <= 1'b1;
            state         <= UNSWAP;
          end else begin
            move_done <= 1'b1;
            state     <= FINISH;
          end
        end else if (wd_expired) begin
          seq_error <= 1'b1;
          ready     <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end else begin
          wdog <= wdog + 1'b1;
        end
        CLEAR_W: if (bus.clear_done) begin
          refresh_start <= 1'b1;
          wdog          <= '0;
          state         <= REFR_W;
        end else if (wd_expired) begin
          seq_error <= 1'b1;
          ready     <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end else begin
          wdog <= wdog + 1'b1;
        end
        REFR_W: if (bus.refresh_done) begin
          match_start <= 1'b1;
          wdog        <= '0;
          state       <= MATCH_W;
        end else if (wd_expired) begin
          seq_error <= 1'b1;
          ready     <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end else begin
          wdog <= wdog + 1'b1;
        end
        UNSWAP, FINISH: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.move_ready    = ready;
  assign bus.busy          = busy;
  assign bus.seq_error     = seq_error;
  assign bus.swap_en       = swap_en;
  assign bus.swap_r0       = r0;
  assign bus.swap_c0       = c0;
  assign bus.swap_r1       = r1;
  assign bus.swap_c1       = c1;
  assign bus.match_start   = match_start;
  assign bus.clear_start   = clear_start;
  assign bus.refresh_start = refresh_start;
  assign bus.move_done     = move_done;
  assign bus.move_rejected = move_rejected;
  assign bus.score         = score;
  assign bus.combo         = combo;
  assign dbg_state         = state;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: reset, illegal moves, cascade scoring,
// score saturation and engine watchdog.
module tb_move_sequencer;
  localparam int SCORE_W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  move_sequencer_if #(.SCORE_W(SCORE_W)) bus();

  move_sequencer #(.SCORE_W(SCORE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Pulse monitor: counts each one-cycle pulse once, remembers last swap coords.
  int         n_swap = 0, n_rej = 0, n_done = 0, n_clr = 0;
  logic [11:0] last_swap = '0;
  always @(posedge clk) begin
    if (bus.swap_en) begin
      n_swap    <= n_swap + 1;
      last_swap <= {bus.swap_r0, bus.swap_c0, bus.swap_r1, bus.swap_c1};
    end
    if (bus.move_rejected) n_rej  <= n_rej + 1;
    if (bus.move_done)     n_done <= n_done + 1;
    if (bus.clear_start)   n_clr  <= n_clr + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.move_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present a move for one edge (caller ensures the sequencer is idle),
  // then scramble the inputs so the latched copy is what gets observed.
  task automatic send_move(input logic [2:0] r0, c0, r1, c1);
    bus.move_valid = 1'b1;
    bus.move_r0 = r0; bus.move_c0 = c0; bus.move_r1 = r1; bus.move_c1 = c1;
    @(negedge clk);
    bus.move_valid = 1'b0;
    bus.move_r0 = 3'd7; bus.move_c0 = 3'd7; bus.move_r1 = 3'd7; bus.move_c1 = 3'd7;
  endtask

  // Wait (bounded) for match_start, then answer with a one-cycle match_done.
  task automatic serve_match(input logic found, input logic [6:0] cnt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.match_start) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      bus.match_done = 1'b1; bus.match_found = found; bus.match_count = cnt;
      @(negedge clk);
      bus.match_done = 1'b0; bus.match_found = 1'b0; bus.match_count = '0;
    end
  endtask

  // kind 1: clear engine, kind 2: refresh engine.
  task automatic serve_engine(input int kind, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((kind == 1) ? bus.clear_start : bus.refresh_start) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      if (kind == 1) bus.clear_done = 1'b1; else bus.refresh_done = 1'b1;
      @(negedge clk);
      bus.clear_done = 1'b0; bus.refresh_done = 1'b0;
    end
  endtask

  // One found-match step of a cascade: match, clear, refresh.
  task automatic cascade_step(input logic [6:0] cnt, output bit ok);
    bit a, b, c;
    serve_match(1'b1, cnt, a);
    serve_engine(1, b);
    serve_engine(2, c);
    ok = a & b & c;
  endtask

  // kind 0: move_rejected, 1: move_done.
  task automatic wait_flag(input int kind, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((kind == 0) ? bus.move_rejected : bus.move_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] st;
    rst_n = 1'b0;
    bus.move_valid = 1'b1;
    bus.move_r0 = 3'd1; bus.move_c0 = 3'd1; bus.move_r1 = 3'd1; bus.move_c1 = 3'd2;
    repeat (3) @(negedge clk);
    st = {bus.move_ready, bus.busy, bus.swap_en, bus.match_start, bus.clear_start,
          bus.refresh_start, bus.move_done, bus.move_rejected, bus.seq_error};
    checks++;
    if (st !== 9'b1_0000_0000) begin errors++; $display("FAIL reset_status: got %b want 100000000", st); end
    checks++;
    if (bus.score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", bus.score); end
    checks++;
    if (bus.combo !== 3'd0) begin errors++; $display("FAIL reset_combo: got %0d want 0", bus.combo); end
    checks++;
    if ({bus.swap_r0, bus.swap_c0, bus.swap_r1, bus.swap_c1} !== 12'd0) begin
      errors++; $display("FAIL reset_coords: got %h want 000", {bus.swap_r0, bus.swap_c0, bus.swap_r1, bus.swap_c1});
    end
    bus.move_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.move_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: busy=%b ready=%b want 0/1", bus.busy, bus.move_ready);
    end
  endtask

  task automatic test_nonadjacent();
    int s_swap, s_rej;
    bit ok;
    s_swap = n_swap; s_rej = n_rej;
    send_move(3'd2, 3'd3, 3'd4, 3'd3);
    checks++;
    if (bus.move_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL accept_busy: ready=%b busy=%b want 0/1", bus.move_ready, bus.busy);
    end
    wait_flag(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nonadj_reject: move_rejected seen=0 want 1"); end
    repeat (3) @(negedge clk);
    checks++;
    if (n_swap - s_swap != 0 || n_rej - s_rej != 1) begin
      errors++; $display("FAIL nonadj_pulses: swaps=%0d rejects=%0d want 0/1", n_swap - s_swap, n_rej - s_rej);
    end
    checks++;
    if (bus.score !== 16'd0 || bus.move_ready !== 1'b1) begin
      errors++; $display("FAIL nonadj_end: score=%0d ready=%b want 0/1", bus.score, bus.move_ready);
    end
  endtask

  task automatic test_no_match();
    int s_swap, s_rej, s_clr, s_done;
    bit ok1, ok2;
    s_swap = n_swap; s_rej = n_rej; s_clr = n_clr; s_done = n_done;
    send_move(3'd2, 3'd3, 3'd2, 3'd4);
    serve_match(1'b0, 7'd0, ok1);
    wait_flag(0, ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL nomatch_flow: match_start=%b reject=%b want 1/1", ok1, ok2); end
    repeat (2) @(negedge clk);
    checks++;
    if (n_swap - s_swap != 2 || n_rej - s_rej != 1 || n_clr != s_clr || n_done != s_done) begin
      errors++; $display("FAIL nomatch_pulses: swaps=%0d rej=%0d clr=%0d done=%0d want 2/1/0/0",
                         n_swap - s_swap, n_rej - s_rej, n_clr - s_clr, n_done - s_done);
    end
    checks++;
    if (last_swap !== {3'd2, 3'd3, 3'd2, 3'd4}) begin
      errors++; $display("FAIL nomatch_coords: got %h want %h", last_swap, {3'd2, 3'd3, 3'd2, 3'd4});
    end
    checks++;
    if (bus.score !== 16'd0 || bus.combo !== 3'd0) begin
      errors++; $display("FAIL nomatch_score: score=%0d combo=%0d want 0/0", bus.score, bus.combo);
    end
  endtask

  task automatic test_cascade();
    int s_swap, s_rej, s_done;
    bit ok1, ok2, ok3, ok4;
    s_swap = n_swap; s_rej = n_rej; s_done = n_done;
    send_move(3'd5, 3'd5, 3'd6, 3'd5);
    // A competing request while busy must be dropped.
    bus.move_valid = 1'b1;
    bus.move_r0 = 3'd0; bus.move_c0 = 3'd0; bus.move_r1 = 3'd0; bus.move_c1 = 3'd1;
    cascade_step(7'd3, ok1);
    cascade_step(7'd4, ok2);
    checks++;
    if (bus.move_ready !== 1'b0) begin errors++; $display("FAIL cascade_ready_busy: got %b want 0", bus.move_ready); end
    serve_match(1'b0, 7'd0, ok3);
    wait_flag(1, ok4);
    bus.move_valid = 1'b0;
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4)) begin
      errors++; $display("FAIL cascade_flow: steps=%b%b%b done=%b want 1111", ok1, ok2, ok3, ok4);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.score !== 16'd11 || bus.combo !== 3'd2) begin
      errors++; $display("FAIL cascade_score: score=%0d combo=%0d want 11/2", bus.score, bus.combo);
    end
    checks++;
    if (n_swap - s_swap != 1 || n_rej != s_rej || n_done - s_done != 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL cascade_pulses: swaps=%0d rej=%0d done=%0d busy=%b want 1/0/1/0",
                         n_swap - s_swap, n_rej - s_rej, n_done - s_done, bus.busy);
    end
    checks++;
    if (last_swap !== {3'd5, 3'd5, 3'd6, 3'd5}) begin
      errors++; $display("FAIL cascade_coords: got %h want %h", last_swap, {3'd5, 3'd5, 3'd6, 3'd5});
    end
  endtask

  task automatic test_saturation();
    bit ok, all_ok;
    int s_done;
    logic [6:0] first_counts [7];
    first_counts = '{7'd58, 7'd64, 7'd64, 7'd64, 7'd64, 7'd64, 7'd64};
    do_reset();
    s_done = n_done;
    all_ok = 1'b1;
    send_move(3'd0, 3'd0, 3'd0, 3'd1);
    // 58*1 + 64*(2..7) = 1786, then 124*64*8 = 63488, then 32*8 = 256 -> 65530
    for (int i = 0; i < 7; i++) begin cascade_step(first_counts[i], ok); all_ok &= ok; end
    for (int i = 0; i < 124; i++) begin cascade_step(7'd64, ok); all_ok &= ok; end
    cascade_step(7'd32, ok); all_ok &= ok;
    checks++;
    if (bus.score !== 16'd65530 || bus.combo !== 3'd7) begin
      errors++; $display("FAIL sat_preload: score=%0d combo=%0d want 65530/7", bus.score, bus.combo);
    end
    cascade_step(7'd64, ok); all_ok &= ok;
    checks++;
    if (bus.score !== 16'd65535) begin errors++; $display("FAIL sat_clip: score=%0d want 65535", bus.score); end
    cascade_step(7'd1, ok); all_ok &= ok;
    serve_match(1'b0, 7'd0, ok); all_ok &= ok;
    wait_flag(1, ok); all_ok &= ok;
    checks++;
    if (!all_ok) begin errors++; $display("FAIL sat_flow: handshake timeout got 0 want 1"); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.score !== 16'd65535 || bus.combo !== 3'd7 || n_done - s_done != 1) begin
      errors++; $display("FAIL sat_hold: score=%0d combo=%0d done=%0d want 65535/7/1",
                         bus.score, bus.combo, n_done - s_done);
    end
  endtask

  task automatic test_timeout();
    int s_swap, s_done, cycles;
    bit ok;
    s_swap = n_swap; s_done = n_done;
    send_move(3'd1, 3'd1, 3'd1, 3'd2);
    serve_match(1'b1, 7'd5, ok);
    checks++;
    if (!ok || bus.clear_start !== 1'b1) begin
      errors++; $display("FAIL timeout_setup: match=%b clear_start=%b want 1/1", ok, bus.clear_start);
    end
    // clear_done withheld: count cycles from clear_start to seq_error.
    cycles = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.seq_error) break;
    end
    checks++;
    if (bus.seq_error !== 1'b1 || cycles != 1023) begin
      errors++; $display("FAIL timeout_latency: seq_error=%b cycles=%0d want 1/1023", bus.seq_error, cycles);
    end
    checks++;
    if (bus.move_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: ready=%b busy=%b want 1/0", bus.move_ready, bus.busy);
    end
    // A late clear_done must be ignored while idle.
    bus.clear_done = 1'b1;
    @(negedge clk);
    bus.clear_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.seq_error !== 1'b1 || bus.refresh_start !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: seq_error=%b refresh_start=%b busy=%b want 1/0/0",
                         bus.seq_error, bus.refresh_start, bus.busy);
    end
    checks++;
    if (n_swap - s_swap != 1 || n_done != s_done) begin
      errors++; $display("FAIL timeout_pulses: swaps=%0d done=%0d want 1/0", n_swap - s_swap, n_done - s_done);
    end
    do_reset();
    checks++;
    if (bus.seq_error !== 1'b0 || bus.score !== 16'd0 || bus.move_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_reset: seq_error=%b score=%0d ready=%b want 0/0/1",
                         bus.seq_error, bus.score, bus.move_ready);
    end
  endtask

  // Global time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    bus.move_valid = 1'b0;
    bus.move_r0 = '0; bus.move_c0 = '0; bus.move_r1 = '0; bus.move_c1 = '0;
    bus.match_done = 1'b0; bus.match_found = 1'b0; bus.match_count = '0;
    bus.clear_done = 1'b0; bus.refresh_done = 1'b0;
    test_reset();
    test_nonadjacent();
    test_no_match();
    test_cascade();
    test_saturation();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
